stage_ram_scheduler: RTL and testbench
======================================

STAGE_RAM_SCHEDULER -- requirements
Module: stage_ram_scheduler

Interface
REQ-001 SHALL have parameter STAGE_W, default 208: stage width in pixels.
REQ-002 SHALL have parameter STAGE_H, default 200: stage height in pixels.
REQ-003 SHALL have parameter WQ_DEPTH, default 4: write-queue depth in entries, a power of two.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports DrawX and DrawY, input, 10 bits each: current VGA pixel coordinates.
REQ-007 SHALL have port blank, input, 1 bit: 1 = VGA active video, 0 = blanking.
REQ-008 SHALL have port pixel_en, input, 1 bit: a one-cycle strobe per new pixel.
REQ-009 SHALL have ports wr_valid (input, 1), wr_addr (input, 16), wr_data (input, 2) and wr_ready (output, 1): the game-logic write handshake.
REQ-010 SHALL have ports clear_start (input, 1), clear_value (input, 2) and clear_busy (output, 1): the whole-stage fill request.
REQ-011 SHALL have ports ram_addr (output, 16), ram_we (output, 1), ram_wdata (output, 2) and ram_rdata (input, 2): a single-port stage RAM with 1-cycle synchronous read.
REQ-012 SHALL have port stage_color_index, output, 2 bits: the palette index sent to the colour mapper.

Function
REQ-013 SHALL treat a cycle as a display slot when pixel_en=1, blank=1, DrawX<STAGE_W and DrawY<STAGE_H; each display slot SHALL read address DrawY*STAGE_W+DrawX (shift-add, 16-bit, no truncation; max 41599).
REQ-014 SHALL give display slots absolute priority; writes SHALL use only non-display cycles, at most one RAM access per cycle.
REQ-015 SHALL drive ram_addr, ram_we and ram_wdata combinationally from the current cycle's grant; ram_we=0 on display and idle cycles.
REQ-016 SHALL output stage_color_index for a pixel strobed in cycle t as registered ram_rdata, valid from cycle t+2; for a non-display pixel strobe the output SHALL be 0 at t+2; with no strobe the output SHALL hold.
REQ-017 SHALL implement a WQ_DEPTH-entry FIFO with wr_ready = !full and state==IDLE; a push SHALL occur when wr_valid & wr_ready, and drains SHALL be FIFO-order, one per free cycle.
REQ-018 SHALL allow a push and a pop in the same cycle, leaving the count unchanged; when full, wr_ready SHALL be 0 and wr_valid SHALL be ignored.
REQ-019 SHALL implement states IDLE, CLR_WAIT and CLEAR.
REQ-020 SHALL transition IDLE->CLR_WAIT on clear_start, latching clear_value; clear_start outside IDLE SHALL be ignored.
REQ-021 SHALL transition CLR_WAIT->CLEAR when the FIFO is empty; the queue SHALL continue draining in CLR_WAIT, with wr_ready=0.
REQ-022 SHALL in CLEAR write the latched value to a 16-bit counter address, 0 to STAGE_W*STAGE_H-1, one per free cycle, then return to IDLE on the cycle after the final write.
REQ-023 SHALL assert clear_busy=1 in CLR_WAIT and CLEAR.
REQ-024 SHALL have display reads continue normally during a clear; a read of a not-yet-cleared address SHALL return the old data.

Reset
REQ-025 SHALL on Reset set state=IDLE, empty the FIFO, zero the clear counter and set stage_color_index=0; during Reset ram_we=0, wr_ready=0 and clear_busy=0.
REQ-026 SHALL on Reset mid-clear or mid-drain abandon the operation without completing it, leaving the RAM contents undefined; wr_ready=1 on the first cycle after Reset.

Configuration
REQ-027 SHALL, when macro STAGE_VBLANK_WR_ONLY_EN is defined, limit queue drains and clear writes to cycles with DrawY>=STAGE_H; when undefined, any non-display cycle SHALL be usable per REQ-014.

Verification
REQ-028 SHALL cover: pre-load addr 634 = 2'b10; strobe at DrawX=10, DrawY=3, blank=1 -> ram_addr=634, ram_we=0, stage_color_index=2'b10 two cycles later.
REQ-029 SHALL cover: strobe at (207,199) -> ram_addr=41599; strobe at (208,0) -> no RAM read, index=0 at t+2.
REQ-030 SHALL cover: push 4 writes with pixel_en held at 1 in the active region -> wr_ready=0 after the 4th push, ram_we never 1; drop pixel_en -> 4 writes in order, 1 per cycle.
REQ-031 SHALL cover: clear_start with 2 queued writes -> both drain, then 41600 writes of clear_value, clear_busy falls after addr 41599, wr_ready=1.
REQ-032 SHALL cover: Reset asserted at clear counter=1000 -> next cycle state IDLE, clear_busy=0, ram_we=0, FIFO empty.
REQ-033 SHALL cover, with STAGE_VBLANK_WR_ONLY_EN defined: a queued write at DrawY=50 with pixel_en=0 -> no ram_we until DrawY>=200.

Source files
------------

// File: rtl/stage_ram_scheduler.sv
// Stage RAM arbiter: display reads always win; queued game writes and whole-stage clears use the
// remaining cycles. Define STAGE_VBLANK_WR_ONLY_EN to restrict writes to rows at or below STAGE_H.
module stage_ram_scheduler #(
  parameter int STAGE_W  = 208,
  parameter int STAGE_H  = 200,
  parameter int WQ_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        pixel_en,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic        wr_ready,
  input  logic        clear_start,
  input  logic [1:0]  clear_value,
  output logic        clear_busy,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [1:0]  ram_wdata,
  input  logic [1:0]  ram_rdata,
  output logic [1:0]  stage_color_index
);

  localparam int              PTR_W    = $clog2(WQ_DEPTH);
  localparam logic [9:0]      W_LIM    = 10'(STAGE_W);
  localparam logic [9:0]      H_LIM    = 10'(STAGE_H);
  localparam logic [15:0]     CLR_LAST = 16'(STAGE_W * STAGE_H - 1);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(WQ_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, CLR_WAIT, CLEAR} state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  data;
  } wq_entry_t;

  state_e            state_q, state_d;
  logic [1:0]        clr_val_q, clr_val_d;
  logic [15:0]       clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  wq_entry_t         mem_q [WQ_DEPTH];
  wq_entry_t         mem_d [WQ_DEPTH];
  logic              strobe_q, strobe_d;
  logic              disp_q, disp_d;
  logic [1:0]        idx_q, idx_d;

  logic              disp_slot;
  logic              free_slot;
  logic [15:0]       pix_addr;
  logic              push;
  logic              pop;
  logic              clr_wr;

  assign disp_slot = pixel_en && blank && (DrawX < W_LIM) && (DrawY < H_LIM);
  // Multiplying by the constant width reduces to a shift-add tree (208 = 128 + 64 + 16).
  assign pix_addr  = 16'(DrawY) * 16'(STAGE_W) + 16'(DrawX);

`ifdef STAGE_VBLANK_WR_ONLY_EN
  assign free_slot = (DrawY >= H_LIM);
`else
  assign free_slot = !disp_slot;
`endif

  assign stage_color_index = idx_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
    state_d    = state_q;
    clr_val_d  = clr_val_q;
    clr_cnt_d  = clr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    pop        = 1'b0;
    clr_wr     = 1'b0;
    wr_ready   = !Reset && (state_q == IDLE) && (cnt_q != CNT_FULL);
    clear_busy = !Reset && (state_q != IDLE);
    push       = wr_valid && wr_ready;

    if (disp_slot) begin
      ram_addr = pix_addr;
    end else if (free_slot && !Reset) begin
      if (state_q == CLEAR) begin
        clr_wr    = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_we    = 1'b1;
        ram_wdata = clr_val_q;
      end else if (cnt_q != '0) begin
        pop       = 1'b1;
        ram_addr  = mem_q[rd_ptr_q].addr;
        ram_we    = 1'b1;
        ram_wdata = mem_q[rd_ptr_q].data;
      end
    end

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d   = CLR_WAIT;
          clr_val_d = clear_value;
        end
      end
      CLR_WAIT: begin
        if (cnt_q == '0) state_d = CLEAR;
      end
      CLEAR: begin
        if (clr_wr) begin
          if (clr_cnt_q == CLR_LAST) begin
            state_d   = IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = '{addr: wr_addr, data: wr_data};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // RAM data for a slot arrives one cycle after the read; it is registered in the next cycle.
  always_comb begin
    strobe_d = pixel_en;
    disp_d   = disp_slot;
    idx_d    = idx_q;
    if (strobe_q) idx_d = disp_q ? ram_rdata : 2'b00;
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      clr_val_q <= '0;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      disp_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_val_q <= clr_val_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
      disp_q    <= disp_d;
      idx_q     <= idx_d;
    end
  end

  // NOTE: queue storage has no reset; the pointers and count already mark every entry invalid.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_stage_ram_scheduler.sv
// Self-checking bench for stage_ram_scheduler: a queue/array reference model of the scheduling
// rules plus a 1-cycle synchronous RAM, driven by directed steps and $urandom traffic.
module tb_stage_ram_scheduler;

  localparam int W     = 208;
  localparam int H     = 200;
  localparam int DEPTH = 4;
  localparam int TOTAL = W * H;

  logic        Clk;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        pixel_en;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_ready;
  logic        clear_start;
  logic [1:0]  clear_value;
  logic        clear_busy;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata;
  logic [1:0]  stage_color_index;

  stage_ram_scheduler #(.STAGE_W(W), .STAGE_H(H), .WQ_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .pixel_en(pixel_en),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stage_color_index(stage_color_index)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [1:0] init_val(input int i);
    return 2'((i * 5 + 1) >> 2);
  endfunction

  // Stage RAM: single port, read data registered one cycle after the address.
  logic [1:0] ram [0:65535];
  logic       ram_init;
  always @(posedge Clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    logic [15:0] a;
    logic [1:0]  d;
  } wr_t;

  wr_t        wq[$];
  int         clr_state;   // 0 none, 1 waiting for the queue, 2 writing
  int         clr_idx;
  logic [1:0] clr_v;
  logic [1:0] exp_idx;
  bit         s1_v;
  logic [1:0] s1_val;
  logic [1:0] ref_mem [0:TOTAL-1];
  int         total;
  int         bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pe, input bit bl, input int x, input int y);
    pixel_en = pe;
    blank    = bl;
    DrawX    = 10'(x);
    DrawY    = 10'(y);
  endtask

  // One clock cycle: inputs were set at the falling edge; check, then advance the model.
  task automatic tick();
    bit disp, free, exp_ready, do_pop, do_clr, q_empty, pe, wv, cs;
    int x, y, pa;
    logic [1:0]  nv, cv, wd;
    logic [15:0] wa;
    #1;
    if (Reset) begin
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_wr_ready", 32'(wr_ready), 0);
      check("rst_clear_busy", 32'(clear_busy), 0);
      @(posedge Clk);
      wq.delete();
      clr_state = 0;
      clr_idx   = 0;
      exp_idx   = 2'b00;
      s1_v      = 1'b0;
      @(negedge Clk);
      return;
    end
    x    = int'(DrawX);
    y    = int'(DrawY);
    pe   = pixel_en;
    disp = pe && blank && (x < W) && (y < H);
    pa   = y * W + x;
`ifdef STAGE_VBLANK_WR_ONLY_EN
    free = (y >= H);
`else
    free = !disp;
`endif
    q_empty   = (wq.size() == 0);
    exp_ready = (wq.size() < DEPTH) && (clr_state == 0);
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    check("clear_busy", 32'(clear_busy), 32'(clr_state != 0));
    check("color_index", 32'(stage_color_index), 32'(exp_idx));
    if (disp) check("disp_addr", 32'(ram_addr), pa);
    do_clr = free && (clr_state == 2);
    do_pop = free && (clr_state != 2) && !q_empty;
    check("ram_we", 32'(ram_we), 32'(do_pop || do_clr));
    if (do_pop) begin
      check("drain_addr", 32'(ram_addr), 32'(wq[0].a));
      check("drain_data", 32'(ram_wdata), 32'(wq[0].d));
    end
    if (do_clr) begin
      check("clear_addr", 32'(ram_addr), clr_idx);
      check("clear_data", 32'(ram_wdata), 32'(clr_v));
    end
    nv = 2'b00;
    if (disp) nv = ref_mem[pa];
    wv = wr_valid;
    wa = wr_addr;
    wd = wr_data;
    cs = clear_start;
    cv = clear_value;
    @(posedge Clk);
    if (s1_v) exp_idx = s1_val;
    s1_v   = pe;
    s1_val = nv;
    if (do_pop) begin
      ref_mem[wq[0].a] = wq[0].d;
      void'(wq.pop_front());
    end
    if (do_clr) begin
      ref_mem[clr_idx] = clr_v;
      if (clr_idx == TOTAL - 1) begin
        clr_state = 0;
        clr_idx   = 0;
      end else begin
        clr_idx++;
      end
    end else if (clr_state == 1 && q_empty) begin
      clr_state = 2;
    end else if (clr_state == 0 && cs) begin
      clr_state = 1;
      clr_v     = cv;
    end
    if (wv && exp_ready) wq.push_back('{a: wa, d: wd});
    @(negedge Clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] saved_addr [4];
    logic        exp_we_y50;
    int          n;

    total = 0;
    bad   = 0;
    wq.delete();
    clr_state = 0;
    clr_idx   = 0;
    clr_v     = 2'b00;
    exp_idx   = 2'b00;
    s1_v      = 1'b0;
    s1_val    = 2'b00;
    for (int i = 0; i < TOTAL; i++) ref_mem[i] = init_val(i);

    // Reset, RAM initialised on the first edge
    Reset       = 1'b1;
    ram_init    = 1'b1;
    drive(0, 0, 0, 0);
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    clear_start = 1'b0;
    clear_value = '0;
    tick();
    ram_init = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    check("post_reset_ready", 32'(wr_ready), 1);
    check("post_reset_index", 32'(stage_color_index), 0);
    check("post_reset_busy", 32'(clear_busy), 0);
    tick();

    // Pre-load address 634 then read it back through a display slot
    drive(0, 0, 0, 220);
    wr_valid = 1'b1;
    wr_addr  = 16'd634;
    wr_data  = 2'b10;
    tick();
    wr_valid = 1'b0;
    tick();
    tick();
    drive(1, 1, 10, 3);
    #1;
    check("req028_addr", 32'(ram_addr), 634);
    check("req028_we", 32'(ram_we), 0);
    tick();
    drive(0, 1, 11, 3);
    tick();
    #1;
    check("req028_index", 32'(stage_color_index), 2);
    tick();

    // Corner of the stage, then the first column past it
    drive(1, 1, 207, 199);
    #1;
    check("req029_last_addr", 32'(ram_addr), 41599);
    tick();
    drive(1, 1, 208, 0);
    tick();
    drive(0, 1, 0, 0);
    #1;
    check("req029_last_index", 32'(stage_color_index), 32'(ref_mem[41599]));
    tick();
    #1;
    check("req029_outside_index", 32'(stage_color_index), 0);
    tick();

    // Fill the queue under continuous display slots, then release the bus
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 20 + k, 5);
      wr_valid = 1'b1;
      wr_addr  = 16'($urandom_range(0, TOTAL - 1));
      wr_data  = 2'($urandom);
      if (k < 4) saved_addr[k] = wr_addr;
      if (k == 4) begin
        #1;
        check("req030_full_ready", 32'(wr_ready), 0);
      end
      tick();
    end
    wr_valid = 1'b0;
    drive(0, 0, 0, 220);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("req030_drain_we", 32'(ram_we), 1);
      check("req030_drain_order", 32'(ram_addr), 32'(saved_addr[k]));
      tick();
    end
    #1;
    check("req030_empty_we", 32'(ram_we), 0);
    check("req030_ready_again", 32'(wr_ready), 1);
    tick();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 260), $urandom_range(0, 262));
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 16'($urandom_range(0, TOTAL - 1));
      wr_data  = 2'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    drive(0, 0, 0, 220);
    for (int k = 0; k < 20; k++) tick();

    // Clear with two writes still queued; display reads continue throughout
    drive(1, 1, 30, 7);
    wr_valid = 1'b1;
    wr_addr  = 16'($urandom_range(0, TOTAL - 1));
    wr_data  = 2'($urandom);
    tick();
    drive(1, 1, 31, 7);
    wr_addr     = 16'($urandom_range(0, TOTAL - 1));
    wr_data     = 2'($urandom);
    clear_start = 1'b1;
    clear_value = 2'b01;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clr_state != 0 && n < 50000) begin
      if ($urandom_range(0, 7) == 0) drive(1, 1, $urandom_range(0, W - 1), $urandom_range(0, H - 1));
      else drive(0, 0, $urandom_range(0, 300), 220);
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 16'($urandom_range(0, TOTAL - 1));
      tick();
      n++;
    end
    wr_valid = 1'b0;
    drive(0, 0, 0, 220);
    #1;
    check("req031_busy_done", 32'(clear_busy), 0);
    check("req031_ready_done", 32'(wr_ready), 1);
    tick();
    drive(1, 1, 10, 3);
    tick();
    drive(0, 1, 0, 0);
    tick();
    #1;
    check("req031_cleared_pixel", 32'(stage_color_index), 1);
    tick();

    // Reset in the middle of a clear
    drive(0, 0, 0, 220);
    clear_start = 1'b1;
    clear_value = 2'b11;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (!(clr_state == 2 && clr_idx == 1000) && n < 5000) begin
      tick();
      n++;
    end
    check("req032_reached_1000", 32'(clear_busy), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("req032_busy", 32'(clear_busy), 0);
    check("req032_we", 32'(ram_we), 0);
    check("req032_ready", 32'(wr_ready), 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 40 + k, 9);
      wr_valid = 1'b1;
      wr_addr  = 16'($urandom_range(0, TOTAL - 1));
      wr_data  = 2'($urandom);
      if (k == 4) begin
        #1;
        check("req032_fifo_was_empty", 32'(wr_ready), 0);
      end
      tick();
    end

    // Reset with a full queue: nothing may drain afterwards
    wr_valid = 1'b0;
    Reset    = 1'b1;
    tick();
    Reset = 1'b0;
    drive(0, 0, 0, 220);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_abandoned", 32'(ram_we), 0);
      tick();
    end

    // A queued write while the beam is inside the stage rows
`ifdef STAGE_VBLANK_WR_ONLY_EN
    exp_we_y50 = 1'b0;
`else
    exp_we_y50 = 1'b1;
`endif
    drive(0, 0, 100, 50);
    wr_valid = 1'b1;
    wr_addr  = 16'($urandom_range(0, TOTAL - 1));
    wr_data  = 2'($urandom);
    tick();
    wr_valid = 1'b0;
    #1;
    check("req033_we_row50", 32'(ram_we), 32'(exp_we_y50));
    tick();
    for (int k = 0; k < 3; k++) tick();
    drive(0, 0, 100, 200);
    #1;
    check("req033_we_row200", 32'(ram_we), 32'(!exp_we_y50));
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
